crtc_timing_counter: RTL and testbench

Programmable, cascadable character/line timing counter for the CRTC datapath. It wraps at a software-set total, flags the displayed region, and generates a sync pulse of programmable position and width. One instance acts as the horizontal counter. Its `carry` drives the `enable` of a second instance, which acts as the vertical counter. Writes to the timing registers are staged and take effect only at a period boundary, so the raster never sees a torn period.

---
 rtl/crtc_timing_counter.sv | 146 ++++++++++++++
 tb/tb_crtc_timing_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_timing_counter.sv
// crtc_timing_counter: programmable, cascadable raster timing counter.
// Counts 0..total, flags the displayed region and emits a sync pulse of
// programmable position and width. Host writes land in a shadow bank that is
// committed to the active bank only at the wrap edge, so a period is never torn.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   enable       count enable (tie high or connect to a lower stage's carry)
//   write_en     register write strobe
//   write_addr   0=total, 1=displayed, 2=sync_pos, 3=sync_width
//   write_data   write value (sync_width uses the low SYNC_WIDTH bits)
//   counter      current count
//   carry        one-cycle pulse on the first cycle at 0 after a wrap
//   display_en   high while counter < active displayed
//   sync         sync pulse
module crtc_timing_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SYNC_WIDTH = 4,
  parameter logic [WIDTH-1:0]      INIT_TOTAL      = WIDTH'(99),
  parameter logic [WIDTH-1:0]      INIT_DISPLAYED  = WIDTH'(80),
  parameter logic [WIDTH-1:0]      INIT_SYNC_POS   = WIDTH'(86),
  parameter logic [SYNC_WIDTH-1:0] INIT_SYNC_WIDTH = SYNC_WIDTH'(10)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             write_en,
  input  logic [1:0]       write_addr,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] counter,
  output logic             carry,
  output logic             display_en,
  output logic             sync
);

  localparam logic [1:0] ADDR_TOTAL      = 2'd0;
  localparam logic [1:0] ADDR_DISPLAYED  = 2'd1;
  localparam logic [1:0] ADDR_SYNC_POS   = 2'd2;
  localparam logic [1:0] ADDR_SYNC_WIDTH = 2'd3;

  // Shadow bank (host side) and active bank (used for counting)
  logic [WIDTH-1:0]      sh_total, sh_disp, sh_spos;
  logic [SYNC_WIDTH-1:0] sh_swidth;
  logic [WIDTH-1:0]      act_total, act_disp, act_spos;
  logic [SYNC_WIDTH-1:0] act_swidth;

  logic [SYNC_WIDTH-1:0] rem;

  logic                  wrap_c;
  logic                  start_c;
  logic [WIDTH-1:0]      counter_next_c;
  logic [WIDTH-1:0]      disp_next_c;
  logic [WIDTH-1:0]      spos_next_c;
  logic [SYNC_WIDTH-1:0] swidth_next_c;
  logic                  sync_next_c;
  logic [SYNC_WIDTH-1:0] rem_next_c;

  // Next count, the register values in force after this edge, and sync update
  always_comb begin
    wrap_c         = enable && (counter == act_total);
    counter_next_c = counter;
    disp_next_c    = act_disp;
    spos_next_c    = act_spos;
    swidth_next_c  = act_swidth;
    sync_next_c    = sync;
    rem_next_c     = rem;
    start_c        = 1'b0;

    if (enable) begin
      if (wrap_c) begin
        counter_next_c = '0;
        disp_next_c    = sh_disp;
        spos_next_c    = sh_spos;
        swidth_next_c  = sh_swidth;
      end else begin
        counter_next_c = counter + WIDTH'(1);
      end

      start_c = (counter_next_c == spos_next_c) && (swidth_next_c != '0);

      // A start while already high simply reloads the remaining count
      if (start_c) begin
        sync_next_c = 1'b1;
        rem_next_c  = swidth_next_c - SYNC_WIDTH'(1);
      end else if (sync) begin
        if (rem == '0) begin
          sync_next_c = 1'b0;
        end else begin
          rem_next_c = rem - SYNC_WIDTH'(1);
        end
      end
    end
  end

  // Host writes into the shadow bank
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_total  <= INIT_TOTAL;
      sh_disp   <= INIT_DISPLAYED;
      sh_spos   <= INIT_SYNC_POS;
      sh_swidth <= INIT_SYNC_WIDTH;
    end else if (write_en) begin
      case (write_addr)
        ADDR_TOTAL:      sh_total  <= write_data;
        ADDR_DISPLAYED:  sh_disp   <= write_data;
        ADDR_SYNC_POS:   sh_spos   <= write_data;
        ADDR_SYNC_WIDTH: sh_swidth <= write_data[SYNC_WIDTH-1:0];
        default:         sh_total  <= sh_total;
      endcase
    end
  end

  // Commit shadow to active on wrap; a same-edge write is seen one wrap later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_total  <= INIT_TOTAL;
      act_disp   <= INIT_DISPLAYED;
      act_spos   <= INIT_SYNC_POS;
      act_swidth <= INIT_SYNC_WIDTH;
    end else if (wrap_c) begin
      act_total  <= sh_total;
      act_disp   <= sh_disp;
      act_spos   <= sh_spos;
      act_swidth <= sh_swidth;
    end
  end

  // Counter and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter    <= '0;
      carry      <= 1'b0;
      display_en <= (INIT_DISPLAYED != '0);
      sync       <= 1'b0;
      rem        <= '0;
    end else begin
      counter    <= counter_next_c;
      carry      <= wrap_c;
      display_en <= (counter_next_c < disp_next_c);
      sync       <= sync_next_c;
      rem        <= rem_next_c;
    end
  end

endmodule

// File: tb/tb_crtc_timing_counter.sv
// Bench for crtc_timing_counter: a count-level reference model checked every
// cycle, plus hand-computed literal checkpoints for the directed scenarios.
module tb_crtc_timing_counter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       write_en = 1'b0;
  logic [1:0] write_addr = 2'd0;
  logic [7:0] write_data = 8'd0;
  logic [7:0] counter;
  logic       carry, display_en, sync;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;

  crtc_timing_counter dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .write_en(write_en),
    .write_addr(write_addr), .write_data(write_data), .counter(counter),
    .carry(carry), .display_en(display_en), .sync(sync)
  );

  always #5 clock = ~clock;

  // Reference model: period position, register banks, sync cycles still owed
  int m_count, m_sync_left;
  bit m_carry;
  int a_total, a_disp, a_spos, a_sw;
  int s_total, s_disp, s_spos, s_sw;

  always @(posedge clock or negedge reset_n) begin : model
    int c, sl, at, ad, ap, aw;
    bit cy;
    if (!reset_n) begin
      m_count <= 0; m_carry <= 0; m_sync_left <= 0;
      a_total <= 99; a_disp <= 80; a_spos <= 86; a_sw <= 10;
      s_total <= 99; s_disp <= 80; s_spos <= 86; s_sw <= 10;
    end else begin
      c = m_count; sl = m_sync_left; cy = 0;
      at = a_total; ad = a_disp; ap = a_spos; aw = a_sw;
      if (enable) begin
        if (c == at) begin
          c = 0; cy = 1;
          at = s_total; ad = s_disp; ap = s_spos; aw = s_sw;
        end else begin
          c = (c + 1) % 256;
        end
        if (c == ap && aw != 0) sl = aw;
        else if (sl > 0) sl = sl - 1;
      end
      m_count <= c; m_carry <= cy; m_sync_left <= sl;
      a_total <= at; a_disp <= ad; a_spos <= ap; a_sw <= aw;
      if (write_en) begin
        case (write_addr)
          2'd0: s_total <= int'(write_data);
          2'd1: s_disp  <= int'(write_data);
          2'd2: s_spos  <= int'(write_data);
          default: s_sw <= int'(write_data[3:0]);
        endcase
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (check_en) begin
      check("cyc_counter", int'(counter), m_count);
      check("cyc_carry", int'(carry), int'(m_carry));
      check("cyc_display_en", int'(display_en), (m_count < a_disp) ? 1 : 0);
      check("cyc_sync", int'(sync), (m_sync_left > 0) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_model(input int value, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_count == value) return;
      @(negedge clock);
    end
    check("wait_timeout", m_count, value);
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
    write_en = 1'b1; write_addr = addr; write_data = data;
    tick(1);
    write_en = 1'b0;
  endtask

  initial begin
    // Reset
    tick(2);
    check_en = 1'b1;
    check("rst_counter", int'(counter), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_display", int'(display_en), 1);
    check("rst_sync", int'(sync), 0);
    reset_n = 1'b1;
    enable = 1'b1;

    // Free run with defaults
    tick(86);
    check("free_cnt86", int'(counter), 86);
    check("free_model86", m_count, 86);
    check("free_sync86", int'(sync), 1);
    check("free_disp86", int'(display_en), 0);
    tick(9);
    check("free_sync95", int'(sync), 1);
    tick(1);
    check("free_sync96", int'(sync), 0);
    tick(4);
    check("free_wrap_cnt", int'(counter), 0);
    check("free_wrap_carry", int'(carry), 1);
    check("free_wrap_disp", int'(display_en), 1);
    tick(1);
    check("free_carry_drop", int'(carry), 0);

    // total=9 written mid-period: current period still ends at 99
    wait_model(3, 10);
    do_write(2'd0, 8'd9);
    wait_model(99, 200);
    tick(1);
    check("t9_wrap1_carry", int'(carry), 1);
    tick(10);
    check("t9_wrap2_cnt", int'(counter), 0);
    check("t9_wrap2_carry", int'(carry), 1);
    tick(9);
    check("t9_cnt9", int'(counter), 9);

    // total=4 written on the wrap edge: effective one period later
    wait_model(9, 20);
    do_write(2'd0, 8'd4);
    check("t4_wrapA_carry", int'(carry), 1);
    check("t4_wrapA_cnt", int'(counter), 0);
    tick(9);
    check("t4_old_total_cnt", int'(counter), 9);
    tick(1);
    check("t4_wrapB_carry", int'(carry), 1);
    tick(4);
    check("t4_new_cnt4", int'(counter), 4);
    tick(1);
    check("t4_wrapC_carry", int'(carry), 1);
    check("t4_wrapC_model", m_count, 0);

    // Sync spanning the wrap: total=9, sync_pos=8, sync_width=5
    do_write(2'd0, 8'd9);
    do_write(2'd2, 8'd8);
    do_write(2'd3, 8'd5);
    tick(30);
    wait_model(7, 20);
    tick(1);
    check("sw_sync_c8", int'(sync), 1);
    tick(1);
    check("sw_sync_c9", int'(sync), 1);
    tick(1);
    check("sw_sync_c0", int'(sync), 1);
    check("sw_carry_c0", int'(carry), 1);
    tick(2);
    check("sw_sync_c2", int'(sync), 1);
    tick(1);
    check("sw_sync_c3", int'(sync), 0);
    check("sw_model_c3", m_sync_left, 0);

    // Enable toggling with total=1
    do_write(2'd0, 8'd1);
    tick(20);
    wait_model(0, 5);
    enable = 1'b1; tick(1);
    check("en_cnt_a", int'(counter), 1);
    enable = 1'b0; tick(1);
    check("en_cnt_b", int'(counter), 1);
    check("en_carry_b", int'(carry), 0);
    enable = 1'b1; tick(1);
    check("en_cnt_c", int'(counter), 0);
    check("en_carry_c", int'(carry), 1);
    enable = 1'b0; tick(1);
    check("en_cnt_d", int'(counter), 0);
    check("en_carry_d", int'(carry), 0);
    enable = 1'b1;

    // Async reset mid-period with sync high and a pending shadow write
    do_write(2'd0, 8'd99);
    do_write(2'd2, 8'd45);
    do_write(2'd3, 8'd10);
    tick(250);
    wait_model(49, 120);
    do_write(2'd1, 8'd20);
    check("ar_pre_cnt", int'(counter), 50);
    check("ar_pre_sync", int'(sync), 1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_counter", int'(counter), 0);
    check("ar_carry", int'(carry), 0);
    check("ar_sync", int'(sync), 0);
    check("ar_display", int'(display_en), 1);
    check("ar_model", m_count, 0);
    tick(2);
    reset_n = 1'b1;
    tick(30);
    check("ar_disp_c30", int'(display_en), 1);
    tick(50);
    check("ar_cnt80", int'(counter), 80);
    check("ar_disp_c80", int'(display_en), 0);
    check("ar_sync_c80", int'(sync), 0);
    tick(6);
    check("ar_sync_c86", int'(sync), 1);
    tick(250);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
